// File: rtl/jcs_pkg.sv
// Shared definitions for the jump/interrupt control unit: opcodes, flag bit
// positions and the return-frame type.
package jcs_pkg;

  localparam logic [4:0] OP_RET  = 5'b10000;
  localparam logic [4:0] OP_CALL = 5'b10001;
  localparam logic [4:0] OP_JMP  = 5'b11000;
  localparam logic [4:0] OP_JC   = 5'b11100;
  localparam logic [4:0] OP_JNC  = 5'b11101;
  localparam logic [4:0] OP_JZ   = 5'b11110;
  localparam logic [4:0] OP_JNZ  = 5'b11111;

  localparam int FLAG_W = 4;
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;

  typedef enum logic {
    FT_CALL = 1'b0,
    FT_IRQ  = 1'b1
  } frame_type_e;

endpackage

// File: rtl/jcs_stack.sv
// DEPTH-entry LIFO for return frames. Push-when-full and pop-when-empty are
// ignored and reported as single-cycle error strobes.
module jcs_stack #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] depth,
  output logic             push_err,
  output logic             pop_err
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;

  assign full     = (cnt == CNT_W'(DEPTH));
  assign empty    = (cnt == '0);
  assign depth    = cnt;
  assign do_pop   = pop && !empty;
  assign do_push  = push && !full && !do_pop;
  assign push_err = push && full;
  assign pop_err  = pop && empty;
  assign wr_idx   = AW'(cnt);
  assign top_idx  = AW'(cnt - CNT_W'(1));
  assign dout     = empty ? '0 : mem[top_idx];

  // NOTE: the frame storage is deliberately left out of reset; only the
  // occupancy count decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= din;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       cnt <= '0;
    else if (do_pop)  cnt <= cnt - CNT_W'(1);
    else if (do_push) cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/jump_ctrl_stack.sv
// Jump/call/return decode, conditional-jump evaluation and prioritised
// interrupt entry with a hardware return stack. CALL support: JCS_CALL_EN.
module jump_ctrl_stack
  import jcs_pkg::*;
#(
  parameter int                ADDR_W     = 8,
  parameter int                INS_W      = 20,
  parameter int                DEPTH      = 4,
  parameter int                N_IRQ      = 2,
  parameter logic [ADDR_W-1:0] VEC_BASE   = 8'hF0,
  parameter int                VEC_STRIDE = 4,
  localparam int               CNT_W      = $clog2(DEPTH + 1),
  localparam int               IDX_W      = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INS_W-1:0]  ins,
  input  logic [ADDR_W-1:0] current_address,
  input  logic [3:0]        flag_ex,
  input  logic [N_IRQ-1:0]  interrupt,
  output logic              pc_mux_sel,
  output logic [ADDR_W-1:0] jmp_loc,
  output logic              flag_restore,
  output logic [3:0]        flag_ret,
  output logic [N_IRQ-1:0]  irq_ack,
  output logic [CNT_W-1:0]  stack_depth,
  output logic              stack_err
);

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [FLAG_W-1:0]  flags;
    frame_type_e        ftype;
  } frame_t;

  localparam int FRAME_W = $bits(frame_t);

  logic [4:0]        opcode;
  logic [ADDR_W-1:0] target;
  logic              is_ret;
  logic              is_call;
  logic              jcc_taken;
  logic              accept;
  logic              push;
  logic              pop;
  frame_t            push_frame;
  frame_t            top_frame;
  logic [FRAME_W-1:0] top_raw;
  logic              full;
  logic              empty;
  logic              push_err;
  logic              pop_err;
  logic              vec_pending;
  logic [IDX_W-1:0]  vec_idx;
  logic [IDX_W-1:0]  irq_sel;
  logic [ADDR_W-1:0] vec_addr;
  logic              in_isr;
  logic              unused_ins;

  assign opcode     = ins[INS_W-1 -: 5];
  assign target     = ins[ADDR_W-1:0];
  assign is_ret     = (opcode == OP_RET);
  assign unused_ins = ^ins[INS_W-6:ADDR_W];
  assign top_frame  = frame_t'(top_raw);
  assign vec_addr   = ADDR_W'(int'(VEC_BASE) + int'(vec_idx) * VEC_STRIDE);

`ifdef JCS_CALL_EN
  assign is_call = (opcode == OP_CALL);
`else
  assign is_call = 1'b0;
`endif

  always_comb begin
    case (opcode)
      OP_JMP:  jcc_taken = 1'b1;
      OP_JC:   jcc_taken = flag_ex[FLAG_C];
      OP_JNC:  jcc_taken = !flag_ex[FLAG_C];
      OP_JZ:   jcc_taken = flag_ex[FLAG_Z];
      OP_JNZ:  jcc_taken = !flag_ex[FLAG_Z];
      default: jcc_taken = 1'b0;
    endcase
  end

  // Lowest set index wins, so scan from the top down.
  always_comb begin
    irq_sel = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (interrupt[i]) irq_sel = IDX_W'(i);
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    pc_mux_sel   = 1'b0;
    jmp_loc      = target;
    flag_restore = 1'b0;
    flag_ret     = '0;
    irq_ack      = '0;
    push         = 1'b0;
    pop          = 1'b0;
    accept       = 1'b0;
    push_frame   = '{addr: current_address + ADDR_W'(1), flags: flag_ex, ftype: FT_CALL};

    if (vec_pending) begin
      // The decode slot holds a flushed instruction during the vector cycle.
      pc_mux_sel       = 1'b1;
      jmp_loc          = vec_addr;
      irq_ack[vec_idx] = 1'b1;
    end else if (is_ret) begin
      pop = 1'b1;
      if (!empty) begin
        pc_mux_sel = 1'b1;
        jmp_loc    = top_frame.addr;
        if (top_frame.ftype == FT_IRQ) begin
          flag_restore = 1'b1;
          flag_ret     = top_frame.flags;
        end
      end
    end else begin
      if (is_call) begin
        push       = 1'b1;
        pc_mux_sel = !full;
      end else begin
        pc_mux_sel = jcc_taken;
      end
      accept = (|interrupt) && !in_isr && !full && !is_call;
      if (accept) begin
        push       = 1'b1;
        push_frame = '{addr:  pc_mux_sel ? jmp_loc : current_address,
                       flags: flag_ex,
                       ftype: FT_IRQ};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vec_pending <= 1'b0;
      vec_idx     <= '0;
      in_isr      <= 1'b0;
      stack_err   <= 1'b0;
    end else begin
      vec_pending <= accept;
      if (accept) begin
        vec_idx <= irq_sel;
        in_isr  <= 1'b1;
      end else if (flag_restore) begin
        in_isr  <= 1'b0;
      end
      if (push_err || pop_err) stack_err <= 1'b1;
    end
  end

  jcs_stack #(
    .WIDTH (FRAME_W),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .din      (push_frame),
    .dout     (top_raw),
    .full     (full),
    .empty    (empty),
    .depth    (stack_depth),
    .push_err (push_err),
    .pop_err  (pop_err)
  );

endmodule

// File: tb/tb_jump_ctrl_stack.sv
// Directed bench for jump_ctrl_stack; CALL scenarios run when JCS_CALL_EN is
// defined, otherwise opcode 10001 is checked to decode as no jump.
module tb_jump_ctrl_stack;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] ins;
  logic [7:0]  current_address;
  logic [3:0]  flag_ex;
  logic [1:0]  interrupt;
  logic        pc_mux_sel;
  logic [7:0]  jmp_loc;
  logic        flag_restore;
  logic [3:0]  flag_ret;
  logic [1:0]  irq_ack;
  logic [2:0]  stack_depth;
  logic        stack_err;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [4:0] RET  = 5'b10000;
  localparam logic [4:0] CALL = 5'b10001;
  localparam logic [4:0] JMP  = 5'b11000;
  localparam logic [4:0] JC   = 5'b11100;
  localparam logic [4:0] JNC  = 5'b11101;
  localparam logic [4:0] JZ   = 5'b11110;
  localparam logic [4:0] JNZ  = 5'b11111;
  localparam logic [19:0] NOP = 20'h00000;

  jump_ctrl_stack dut (
    .clk             (clk),
    .reset           (reset),
    .ins             (ins),
    .current_address (current_address),
    .flag_ex         (flag_ex),
    .interrupt       (interrupt),
    .pc_mux_sel      (pc_mux_sel),
    .jmp_loc         (jmp_loc),
    .flag_restore    (flag_restore),
    .flag_ret        (flag_ret),
    .irq_ack         (irq_ack),
    .stack_depth     (stack_depth),
    .stack_err       (stack_err)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] mk(input logic [4:0] op, input logic [7:0] tgt);
    return {op, 7'd0, tgt};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; ins = NOP; current_address = 8'h00; flag_ex = 4'h0; interrupt = 2'b00;
    #1;
    check("rst_depth", stack_depth, 0);
    check("rst_err", stack_err, 0);
    check("rst_ack", irq_ack, 0);
    check("rst_pcsel", pc_mux_sel, 0);
    check("rst_frest", flag_restore, 0);
    @(negedge clk) reset = 1'b1;

    // Conditional jumps
    @(negedge clk) ins = mk(JZ, 8'h3C); flag_ex = 4'b0010;
    #1 check("jz_taken", pc_mux_sel, 1); check("jz_loc", jmp_loc, 8'h3C);
    flag_ex = 4'b0000;
    #1 check("jz_not", pc_mux_sel, 0);
    ins = mk(JNZ, 8'h12);
    #1 check("jnz_taken", pc_mux_sel, 1);
    ins = mk(JC, 8'h34); flag_ex = 4'b0001;
    #1 check("jc_taken", pc_mux_sel, 1); check("jc_loc", jmp_loc, 8'h34);
    ins = mk(JNC, 8'h34);
    #1 check("jnc_not", pc_mux_sel, 0);
    ins = mk(JMP, 8'h77); flag_ex = 4'h0;
    #1 check("jmp_taken", pc_mux_sel, 1); check("jmp_loc", jmp_loc, 8'h77);
`ifndef JCS_CALL_EN
    ins = mk(CALL, 8'h40);
    #1 check("call_off", pc_mux_sel, 0);
`endif

    // Interrupt entry, both lines high: channel 0 wins
    @(negedge clk) ins = NOP; current_address = 8'h20; flag_ex = 4'hA; interrupt = 2'b11;
    #1 check("irq_noack_yet", irq_ack, 0);
    @(negedge clk) ins = mk(RET, 8'h00);
    #1 check("vec_pcsel", pc_mux_sel, 1);
    check("vec_loc", jmp_loc, 8'hF0);
    check("vec_ack", irq_ack, 2'b01);
    check("vec_depth", stack_depth, 1);
    check("vec_ret_ignored", flag_restore, 0);
    @(negedge clk) ins = NOP;
    #1 check("isr_noack", irq_ack, 0);
    @(negedge clk) interrupt = 2'b00;
    #1 check("isr_no_second", stack_depth, 1);
`ifdef JCS_CALL_EN
    ins = mk(CALL, 8'h40); current_address = 8'h10; flag_ex = 4'h3;
    #1 check("call_pcsel", pc_mux_sel, 1); check("call_loc", jmp_loc, 8'h40);
    @(negedge clk) ins = mk(RET, 8'h00);
    #1 check("call_depth", stack_depth, 2);
    check("cret_loc", jmp_loc, 8'h11);
    check("cret_pcsel", pc_mux_sel, 1);
    check("cret_frest", flag_restore, 0);
    @(negedge clk) ins = mk(RET, 8'h00);
`else
    ins = mk(RET, 8'h00);
`endif
    #1 check("iret_loc", jmp_loc, 8'h20);
    check("iret_frest", flag_restore, 1);
    check("iret_flags", flag_ret, 4'hA);
    @(negedge clk) ins = NOP;
    #1 check("iret_depth", stack_depth, 0);
    check("iret_noerr", stack_err, 0);

    // Underflow
    ins = mk(RET, 8'h00);
    #1 check("uflow_pcsel", pc_mux_sel, 0);
    @(negedge clk) ins = NOP;
    #1 check("uflow_err", stack_err, 1);
    reset = 1'b0;
    #1 check("rst2_err", stack_err, 0); check("rst2_depth", stack_depth, 0);
    @(negedge clk) reset = 1'b1;

    // Interrupt coinciding with a taken JMP, channel 1
    @(negedge clk) ins = mk(JMP, 8'h55); current_address = 8'h30; flag_ex = 4'h5; interrupt = 2'b10;
    #1 check("jirq_pcsel", pc_mux_sel, 1);
    @(negedge clk) ins = NOP; interrupt = 2'b00;
    #1 check("v1_loc", jmp_loc, 8'hF4);
    check("v1_ack", irq_ack, 2'b10);
    check("v1_depth", stack_depth, 1);
    @(negedge clk) ins = mk(RET, 8'h00);
    #1 check("jirq_ret_loc", jmp_loc, 8'h55);
    check("jirq_ret_flags", flag_ret, 4'h5);
    @(negedge clk) ins = NOP;

    // Reset in the middle of a vector cycle
    @(negedge clk) ins = mk(JMP, 8'h55); interrupt = 2'b01;
    @(negedge clk) ins = NOP; interrupt = 2'b00;
    #1 check("v0_loc", jmp_loc, 8'hF0); check("v0_ack", irq_ack, 2'b01);
    reset = 1'b0;
    #1 check("vrst_ack", irq_ack, 0);
    check("vrst_pcsel", pc_mux_sel, 0);
    check("vrst_depth", stack_depth, 0);
    ins = mk(JMP, 8'h66);
    #1 check("vrst_decode", jmp_loc, 8'h66); check("vrst_decode_sel", pc_mux_sel, 1);
    @(negedge clk) reset = 1'b1; ins = NOP;

`ifdef JCS_CALL_EN
    // Overflow, and an interrupt held off by the full stack
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) ins = mk(CALL, 8'h80 + 8'(i)); current_address = 8'(i);
      #1 check("fill_pcsel", pc_mux_sel, 1);
    end
    @(negedge clk) ins = mk(CALL, 8'h90);
    #1 check("ovf_pcsel", pc_mux_sel, 0); check("ovf_depth", stack_depth, 4);
    @(negedge clk) ins = NOP; interrupt = 2'b01;
    #1 check("ovf_err", stack_err, 1);
    @(negedge clk);
    #1 check("full_noack", irq_ack, 0); check("full_depth", stack_depth, 4);
    ins = mk(RET, 8'h00);
    #1 check("full_ret_loc", jmp_loc, 8'h04);
    @(negedge clk) ins = NOP;
    #1 check("full_pop", stack_depth, 3);
    @(negedge clk);
    #1 check("late_ack", irq_ack, 2'b01); check("late_depth", stack_depth, 4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
